tod_event_encoder: RTL and testbench
====================================

Name: tod_event_encoder

Overview:
- Upstream stage of the event receiver's time-of-day decoder.
- Merges time-of-day protocol events into an outgoing 8-bit event stream:
  - 32 shift-bit events (0x70 = zero, 0x71 = one), MSB first, carrying the seconds value for the coming second.
  - One seconds marker (0x7D), emitted on each PPS strobe.
- Ordinary upstream events are passed through. Time-of-day events are inserted only into idle slots; the marker is the exception and is always sent.

Parameters:
- BIT_SPACING, 4: minimum clock cycles between successive shift-bit events (legal range 1..255).
- START_DELAY, 16: cycles after a marker or load before the first shift bit becomes eligible (legal range 1..65535).

Ports:
- Clock, input, 1: event clock.
- Reset, input, 1: asynchronous, active-high reset.
- ppsStrobe, input, 1: single-cycle pulse, already synchronous to Clock; marks the start of a second.
- secondsLoad, input, 1: single-cycle pulse; loads secondsValue as the next value to transmit.
- secondsValue, input, 32: seconds value captured on secondsLoad.
- EventIn, input, 8: upstream event code; 0x00 means an idle slot.
- EventOut, output, 8: merged event stream, registered.
- shiftBusy, output, 1: high while the shift sequence is armed or in progress.
- droppedCount, output, 10: upstream events discarded; wraps.
- lateCount, output, 10: markers sent before all 32 bits were shifted; wraps.

Behaviour:
- Reset (async assert, sync release):
  - EventOut = 0, shiftBusy = 0, droppedCount = 0, lateCount = 0.
  - secondsNext = 0, state IDLE, bit index = 31, spacing/delay counters = 0.
- Internal state: secondsNext (32 bits) is the value being, or about to be, shifted.
- States:
  - IDLE: no shift activity. Entered only from reset.
  - DELAY: counts START_DELAY cycles, then goes to SHIFT.
  - SHIFT: sends bits secondsNext[31] down to [0].
  - WAIT_PPS: all 32 bits sent; waits for the next PPS.
- Transitions:
  - ppsStrobe in any state → DELAY, and secondsNext <= secondsNext + 1 (mod 2^32).
  - secondsLoad in any state → DELAY, secondsNext <= secondsValue, no marker emitted.
  - If ppsStrobe and secondsLoad arrive together: emit the marker, and secondsNext <= secondsValue (the load wins over the increment).
  - DELAY counter reaches START_DELAY → SHIFT, bit index = 31, spacing counter satisfied (the first bit is eligible immediately).
  - SHIFT: after bit 0 is emitted → WAIT_PPS.
- shiftBusy = 1 in DELAY and SHIFT; 0 in IDLE and WAIT_PPS.
- Output slot selection (evaluated every cycle; EventOut updates on the next edge, so latency is 1 cycle), in priority order:
  1. ppsStrobe: EventOut <= 0x7D.
     - If EventIn is non-zero in the same cycle, droppedCount increments.
     - If the state is DELAY or SHIFT, lateCount increments; the remaining bits of the old sequence are abandoned.
  2. EventIn is 0x70, 0x71 or 0x7D (protocol codes from upstream): EventOut <= 0x00 and droppedCount increments. Upstream must never forge protocol events.
  3. EventIn non-zero: EventOut <= EventIn. A pending shift bit is deferred, and the spacing counter keeps running.
  4. State is SHIFT, the spacing counter has reached BIT_SPACING, and EventIn = 0x00:
     - EventOut <= 0x70 | secondsNext[bit index].
     - Bit index decrements; the spacing counter restarts at 1.
  5. Otherwise: EventOut <= 0x00.
- Spacing counter: saturates at BIT_SPACING, so a deferred bit goes out in the first idle slot.
- Counters: droppedCount and lateCount wrap from 1023 to 0.
- Consecutive secondsLoad pulses: each one restarts DELAY; only the last value is transmitted.
- Reset asserted mid-sequence: everything returns to reset values at once; no partial event is emitted after reset.

Test Plan:
1. Reset release, then secondsLoad with secondsValue = 0x5A5A0001, EventIn = 0 → after 16 cycles, 32 shift events spaced 4 cycles apart, with codes matching 0x5A5A0001 MSB first (first 0x70, second 0x71); shiftBusy then goes low.
2. After test 1, pulse ppsStrobe → EventOut = 0x7D exactly 1 cycle later; the following sequence shifts 0x5A5A0002; lateCount = 0.
3. ppsStrobe 50 cycles after a load (fewer than 32 bits sent) → marker emitted, lateCount = 1, the new sequence carries value + 1.
4. EventIn = 0x33 on every cycle during SHIFT for 20 cycles → 0x33 passed through each cycle, no bits sent; the next bit appears in the first idle slot; droppedCount = 0.
5. ppsStrobe coincident with EventIn = 0x22 → EventOut = 0x7D, droppedCount = 1. Separately, EventIn = 0x71 → EventOut = 0x00, droppedCount = 2.
6. Assert Reset asynchronously in the middle of a bit → EventOut = 0 before the next edge, all counters 0, state IDLE, no shift events until the next load or PPS.

Source files
------------

// File: rtl/tod_event_encoder_if.sv
// Event-stream bundle between the time-of-day encoder and its neighbours.
// The master side drives strobes and upstream events; the slave side is the encoder.
interface tod_event_encoder_if;
  logic        ppsStrobe;
  logic        secondsLoad;
  logic [31:0] secondsValue;
  logic [7:0]  EventIn;
  logic [7:0]  EventOut;
  logic        shiftBusy;
  logic [9:0]  droppedCount;
  logic [9:0]  lateCount;

  modport master (
    output ppsStrobe, secondsLoad, secondsValue, EventIn,
    input  EventOut, shiftBusy, droppedCount, lateCount
  );

  modport slave (
    input  ppsStrobe, secondsLoad, secondsValue, EventIn,
    output EventOut, shiftBusy, droppedCount, lateCount
  );
endinterface

// File: rtl/tod_event_encoder.sv
// Merges the seconds marker and 32 MSB-first shift-bit events into the upstream
// event stream, using idle slots for the bits and forcing the marker on every PPS.
module tod_event_encoder #(
  parameter int unsigned BIT_SPACING = 4,
  parameter int unsigned START_DELAY = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  tod_event_encoder_if.slave   bus
);

  localparam logic [7:0]  SPACING  = 8'(BIT_SPACING);
  localparam logic [15:0] DLY_LAST = 16'(START_DELAY - 1);
  localparam logic [7:0]  EV_ZERO  = 8'h70;
  localparam logic [7:0]  EV_ONE   = 8'h71;
  localparam logic [7:0]  EV_MARK  = 8'h7D;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, WAIT_PPS} state_t;

  state_t      state_q, state_d;
  logic [31:0] sec_q, sec_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  sp_q, sp_d;
  logic [15:0] dly_q, dly_d;
  logic [7:0]  evt_q, evt_d;
  logic [9:0]  drop_q, drop_d;
  logic [9:0]  late_q, late_d;

  logic is_proto;
  logic bit_slot;

  assign is_proto = (bus.EventIn == EV_ZERO) || (bus.EventIn == EV_ONE) ||
                    (bus.EventIn == EV_MARK);
  // A restart (PPS or load) in the same cycle takes the slot away from the old sequence.
  assign bit_slot = (state_q == SHIFT) && (sp_q == SPACING) && (bus.EventIn == 8'h00) &&
                    !bus.ppsStrobe && !bus.secondsLoad;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      idx_q   <= '1;
      sp_q    <= '0;
      dly_q   <= '0;
      evt_q   <= '0;
      drop_q  <= '0;
      late_q  <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
      dly_q   <= dly_d;
      evt_q   <= evt_d;
      drop_q  <= drop_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    sp_d    = sp_q;
    if ((state_q == SHIFT) && (sp_q < SPACING)) begin
      sp_d = sp_q + 8'd1;
    end

    case (state_q)
      DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = SHIFT;
          idx_d   = 5'd31;
          sp_d    = SPACING;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      SHIFT: begin
        if (bit_slot) begin
          sp_d = 8'd1;
          if (idx_q == 5'd0) begin
            state_d = WAIT_PPS;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      default: ;
    endcase

    if (bus.ppsStrobe || bus.secondsLoad) begin
      state_d = DELAY;
      dly_d   = '0;
      idx_d   = 5'd31;
      sp_d    = '0;
      sec_d   = bus.secondsLoad ? bus.secondsValue : (sec_q + 32'd1);
    end
  end

  always_comb begin
    evt_d  = 8'h00;
    drop_d = drop_q;
    late_d = late_q;
    if (bus.ppsStrobe) begin
      evt_d = EV_MARK;
      if (bus.EventIn != 8'h00) begin
        drop_d = drop_q + 10'd1;
      end
      if ((state_q == DELAY) || (state_q == SHIFT)) begin
        late_d = late_q + 10'd1;
      end
    end else if (is_proto) begin
      drop_d = drop_q + 10'd1;
    end else if (bus.EventIn != 8'h00) begin
      evt_d = bus.EventIn;
    end else if (bit_slot) begin
      evt_d = EV_ZERO | {7'd0, sec_q[idx_q]};
    end
  end

  always_comb begin
    bus.shiftBusy = (state_q == DELAY) || (state_q == SHIFT);
  end

  assign bus.EventOut     = evt_q;
  assign bus.droppedCount = drop_q;
  assign bus.lateCount    = late_q;

endmodule

// File: tb/tb_tod_event_encoder.sv
// Directed bench for tod_event_encoder: expected events are queued with their
// due cycle as stimulus is driven, and every cycle's EventOut is checked against it.
module tb_tod_event_encoder;

  localparam int unsigned SP = 4;
  localparam int unsigned SD = 16;

  logic clk = 1'b0;
  logic Reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tod_event_encoder_if bus ();

  tod_event_encoder #(.BIT_SPACING(SP), .START_DELAY(SD)) dut (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    logic [7:0] code;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One cycle: move to the next falling edge and compare EventOut with the scoreboard.
  task automatic tick();
    logic [7:0] want;
    @(negedge clk);
    want = 8'h00;
    if ((q.size() > 0) && (q[0].due == cyc)) begin
      want = q[0].code;
      void'(q.pop_front());
    end
    check($sformatf("evt@%0d", cyc), {24'd0, bus.EventOut}, {24'd0, want});
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int due, input logic [7:0] code);
    exp_t e;
    e.due  = due;
    e.code = code;
    q.push_back(e);
  endtask

  task automatic push_bits(input int first, input logic [31:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      push(first + SP * (i - lo), 8'h70 | {7'd0, v[31-i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k1, k2, k3, k4, k5;
    logic [31:0] v;

    Reset            = 1'b1;
    bus.ppsStrobe    = 1'b0;
    bus.secondsLoad  = 1'b0;
    bus.secondsValue = '0;
    bus.EventIn      = '0;
    #1;
    check("rst_evt",   {24'd0, bus.EventOut},     32'h0);
    check("rst_busy",  {31'd0, bus.shiftBusy},    32'h0);
    check("rst_drop",  {22'd0, bus.droppedCount}, 32'h0);
    check("rst_late",  {22'd0, bus.lateCount},    32'h0);
    repeat (3) tick();
    Reset = 1'b0;
    tick();

    // Load 0x5A5A0001: 16-cycle delay, then 32 bits every 4 cycles.
    k1 = cyc + 1;
    bus.secondsLoad  = 1'b1;
    bus.secondsValue = 32'h5A5A_0001;
    push_bits(k1 + SD + 1, 32'h5A5A_0001, 0, 31);
    tick();
    bus.secondsLoad = 1'b0;
    run_to(k1 + 20);
    check("t1_busy_mid", {31'd0, bus.shiftBusy}, 32'h1);
    run_to(k1 + SD + 1 + SP * 31);
    check("t1_busy_end", {31'd0, bus.shiftBusy}, 32'h0);

    // PPS after a complete sequence: on-time marker, value increments.
    run_to(cyc + 5);
    k2 = cyc + 1;
    bus.ppsStrobe = 1'b1;
    push(k2, 8'h7D);
    push_bits(k2 + SD + 1, 32'h5A5A_0002, 0, 31);
    tick();
    bus.ppsStrobe = 1'b0;
    run_to(k2 + SD + 1 + SP * 31);
    check("t2_late", {22'd0, bus.lateCount}, 32'h0);
    check("t2_busy", {31'd0, bus.shiftBusy}, 32'h0);

    // Early PPS mid-sequence, followed by upstream traffic deferring a bit.
    run_to(cyc + 3);
    v  = 32'hC3C3_7FFF;
    k3 = cyc + 1;
    bus.secondsLoad  = 1'b1;
    bus.secondsValue = v;
    push_bits(k3 + SD + 1, v, 0, 8);
    tick();
    bus.secondsLoad = 1'b0;
    k4 = k3 + 50;
    run_to(k4 - 1);
    bus.ppsStrobe = 1'b1;
    push(k4, 8'h7D);
    push_bits(k4 + SD + 1, v + 32'd1, 0, 1);
    for (int e = k4 + 22; e <= k4 + 41; e++) push(e, 8'h33);
    push_bits(k4 + 42, v + 32'd1, 2, 31);
    tick();
    bus.ppsStrobe = 1'b0;
    check("t3_late", {22'd0, bus.lateCount}, 32'h1);

    run_to(k4 + 21);
    bus.EventIn = 8'h33;
    run_to(k4 + 41);
    bus.EventIn = 8'h00;
    check("t4_busy_hold", {31'd0, bus.shiftBusy}, 32'h1);
    run_to(k4 + 42 + SP * 29);
    check("t4_busy_end", {31'd0, bus.shiftBusy}, 32'h0);
    check("t4_drop",     {22'd0, bus.droppedCount}, 32'h0);

    // Marker overrides an upstream event; forged protocol code is blanked.
    k5 = cyc + 5;
    run_to(k5 - 1);
    bus.ppsStrobe = 1'b1;
    bus.EventIn   = 8'h22;
    push(k5, 8'h7D);
    push_bits(k5 + SD + 1, v + 32'd2, 0, 3);
    tick();
    bus.ppsStrobe = 1'b0;
    bus.EventIn   = 8'h00;
    check("t5_drop1", {22'd0, bus.droppedCount}, 32'h1);
    check("t5_late",  {22'd0, bus.lateCount},    32'h1);
    run_to(k5 + 2);
    bus.EventIn = 8'h71;
    tick();
    bus.EventIn = 8'h00;
    check("t5_drop2", {22'd0, bus.droppedCount}, 32'h2);

    // Asynchronous reset while bit 3 is on the output.
    run_to(k5 + SD + 1 + SP * 3);
    #1 Reset = 1'b1;
    #1;
    check("t6_evt",  {24'd0, bus.EventOut},     32'h0);
    check("t6_drop", {22'd0, bus.droppedCount}, 32'h0);
    check("t6_late", {22'd0, bus.lateCount},    32'h0);
    check("t6_busy", {31'd0, bus.shiftBusy},    32'h0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (200) tick();
    check("t6_idle_busy", {31'd0, bus.shiftBusy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
